// File: rtl/reg_scoreboard.sv
`timescale 1ns/1ps
// ID-stage GPR hazard scoreboard: counts in-flight writes per register, stalls ID on
// RAW hazards or counter saturation, and retires pending writes on the WB write port.
module reg_scoreboard #(
    parameter int CNT_W  = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic       reg_read_en_1,
    input  logic       reg_read_en_2,
    input  logic [4:0] reg_addr_1,
    input  logic [4:0] reg_addr_2,
    input  logic       reg_write_en,
    input  logic [4:0] reg_write_addr,
    input  logic       wb_write_en,
    input  logic [4:0] wb_write_addr,
    input  logic       flush,
    output logic       stall,
    output logic       issue,
    output logic       sb_empty,
    output logic       retire_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Entry 0 exists only so any 5-bit address can index the array; it stays 0.
    logic [CNT_W-1:0] cnt [32];
    logic             retire_err_q;

    logic        wb_ret;
    logic        ret_1;
    logic        ret_2;
    logic        ret_w;
    logic        haz_1;
    logic        haz_2;
    logic        sat;
    logic        any_pending;
    logic [31:0] inc_vec;
    logic [31:0] dec_vec;

    // Counter step; never wraps because sat stall blocks an inc at CNT_MAX.
    function automatic logic [CNT_W-1:0] cnt_step(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec && cur != CNT_MAX) begin
            nxt = cur + CNT_ONE;
        end else if (dec && !inc && cur != '0) begin
            nxt = cur - CNT_ONE;
        end
        return nxt;
    endfunction

    function automatic logic read_hazard(
        input logic             en,
        input logic [4:0]       addr,
        input logic [CNT_W-1:0] cur,
        input logic             ret
    );
        return en && (addr != 5'd0) && (cur != '0) &&
               !(BYPASS && (cur == CNT_ONE) && ret);
    endfunction

    always_comb begin
        wb_ret = wb_write_en && (wb_write_addr != 5'd0) && !flush;
        ret_1  = wb_ret && (wb_write_addr == reg_addr_1);
        ret_2  = wb_ret && (wb_write_addr == reg_addr_2);
        ret_w  = wb_ret && (wb_write_addr == reg_write_addr);

        haz_1  = read_hazard(reg_read_en_1, reg_addr_1, cnt[reg_addr_1], ret_1);
        haz_2  = read_hazard(reg_read_en_2, reg_addr_2, cnt[reg_addr_2], ret_2);
        sat    = reg_write_en && (reg_write_addr != 5'd0) &&
                 (cnt[reg_write_addr] == CNT_MAX) && !ret_w;

        stall  = !rst && id_valid && (haz_1 || haz_2 || sat);
        issue  = !rst && id_valid && !stall && !flush;
    end

    always_comb begin
        any_pending = 1'b0;
        inc_vec     = '0;
        dec_vec     = '0;
        for (int i = 1; i < 32; i++) begin
            any_pending = any_pending || (cnt[i] != '0);
            inc_vec[i]  = issue && reg_write_en && (reg_write_addr == 5'(i));
            dec_vec[i]  = wb_ret && (wb_write_addr == 5'(i)) && (cnt[i] != '0);
        end
    end

    assign sb_empty   = rst || !any_pending;
    assign retire_err = retire_err_q;

    // State update: reset beats flush, flush discards everything including WB retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
            retire_err_q <= 1'b0;
        end else if (flush) begin
            for (int i = 1; i < 32; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (wb_ret && (cnt[wb_write_addr] == '0)) begin
                retire_err_q <= 1'b1;
            end
            for (int i = 1; i < 32; i++) begin
                cnt[i] <= cnt_step(cnt[i], inc_vec[i], dec_vec[i]);
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
`timescale 1ns/1ps
// Scoreboard bench for reg_scoreboard: directed scenarios plus random traffic,
// checked against a per-register pending-count model.
module tb_reg_scoreboard;

    localparam int CNT_W   = 2;
    localparam bit BYPASS  = 1'b1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic       reg_read_en_1;
    logic       reg_read_en_2;
    logic [4:0] reg_addr_1;
    logic [4:0] reg_addr_2;
    logic       reg_write_en;
    logic [4:0] reg_write_addr;
    logic       wb_write_en;
    logic [4:0] wb_write_addr;
    logic       flush;
    logic       stall;
    logic       issue;
    logic       sb_empty;
    logic       retire_err;

    reg_scoreboard #(.CNT_W(CNT_W), .BYPASS(BYPASS)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .reg_read_en_1  (reg_read_en_1),
        .reg_read_en_2  (reg_read_en_2),
        .reg_addr_1     (reg_addr_1),
        .reg_addr_2     (reg_addr_2),
        .reg_write_en   (reg_write_en),
        .reg_write_addr (reg_write_addr),
        .wb_write_en    (wb_write_en),
        .wb_write_addr  (wb_write_addr),
        .flush          (flush),
        .stall          (stall),
        .issue          (issue),
        .sb_empty       (sb_empty),
        .retire_err     (retire_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit stall;
        bit issue;
        bit empty;
        bit err;
    } exp_t;

    exp_t q[$];
    int   mcnt[32];
    bit   merr;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ret(input int a, input bit wbe, input int wba, input bit fl);
        return wbe && (wba == a) && (a != 0) && !fl;
    endfunction

    // One cycle of stimulus: expected outputs come from the pending counts before the edge.
    task automatic drive(input bit r, input bit v,
                         input bit e1, input int a1, input bit e2, input int a2,
                         input bit we, input int wa,
                         input bit wbe, input int wba, input bit fl);
        exp_t e;
        bit   h1, h2, sat, empty;
        @(posedge clk);
        #1;
        rst = r; id_valid = v;
        reg_read_en_1 = e1; reg_addr_1 = 5'(a1);
        reg_read_en_2 = e2; reg_addr_2 = 5'(a2);
        reg_write_en = we; reg_write_addr = 5'(wa);
        wb_write_en = wbe; wb_write_addr = 5'(wba);
        flush = fl;

        h1  = e1 && a1 != 0 && mcnt[a1] != 0 &&
              !(BYPASS && mcnt[a1] == 1 && m_ret(a1, wbe, wba, fl));
        h2  = e2 && a2 != 0 && mcnt[a2] != 0 &&
              !(BYPASS && mcnt[a2] == 1 && m_ret(a2, wbe, wba, fl));
        sat = we && wa != 0 && mcnt[wa] == CNT_MAX && !m_ret(wa, wbe, wba, fl);
        empty = 1'b1;
        for (int i = 0; i < 32; i++) if (mcnt[i] != 0) empty = 1'b0;

        e.stall = !r && v && (h1 || h2 || sat);
        e.issue = !r && v && !e.stall && !fl;
        e.empty = r || empty;
        e.err   = merr;
        q.push_back(e);

        if (r) begin
            for (int i = 0; i < 32; i++) mcnt[i] = 0;
            merr = 1'b0;
        end else if (fl) begin
            for (int i = 0; i < 32; i++) mcnt[i] = 0;
        end else begin
            if (wbe && wba != 0) begin
                if (mcnt[wba] == 0) merr = 1'b1;
                else mcnt[wba] = mcnt[wba] - 1;
            end
            if (e.issue && we && wa != 0) mcnt[wa] = mcnt[wa] + 1;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall", stall, e.stall);
                chk("issue", issue, e.issue);
                chk("sb_empty", sb_empty, e.empty);
                chk("retire_err", retire_err, e.err);
            end
        end
    end

    function automatic int pick_addr();
        int tbl[6] = '{0, 3, 5, 7, 9, 31};
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
        return tbl[$urandom_range(0, 5)];
    endfunction

    initial begin : stimulus
        int pend[$];
        int wba;
        bit wbe;
        rst = 1'b1; id_valid = 0; reg_read_en_1 = 0; reg_read_en_2 = 0;
        reg_addr_1 = 0; reg_addr_2 = 0; reg_write_en = 0; reg_write_addr = 0;
        wb_write_en = 0; wb_write_addr = 0; flush = 0;
        for (int i = 0; i < 32; i++) mcnt[i] = 0;
        merr = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held with hazard-looking traffic
        drive(1, 1, 1, 5, 1, 7, 1, 5, 1, 3, 0);
        drive(1, 1, 1, 5, 1, 5, 1, 5, 0, 0, 0);
        idle();

        // RAW on $5, retired by WB with bypass
        drive(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        drive(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 5, 1, 5, 1, 6, 0, 0, 0);
        drive(0, 1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
        drive(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // $0 never tracked
        drive(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        idle();

        // Saturation on $7, then write alongside a retire of $7
        repeat (3) drive(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        drive(0, 1, 1, 7, 0, 0, 1, 7, 1, 7, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        idle();

        // Simultaneous issue and retire on $9, self-read of own destination
        drive(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
        drive(0, 1, 1, 12, 0, 0, 1, 12, 0, 0, 0);
        idle();

        // Flush with several pending regs, then an errant retire
        drive(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
        drive(0, 1, 1, 3, 1, 10, 1, 13, 1, 11, 1);
        drive(0, 1, 1, 3, 1, 10, 1, 14, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        repeat (3) idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0);
        idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            pend.delete();
            for (int i = 1; i < 32; i++) if (mcnt[i] != 0) pend.push_back(i);
            wbe = ($urandom_range(0, 9) < 4);
            if (pend.size() > 0 && $urandom_range(0, 9) < 8)
                wba = pend[$urandom_range(0, pend.size() - 1)];
            else
                wba = pick_addr();
            drive(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 9) < 8),
                  $urandom_range(0, 1), pick_addr(),
                  $urandom_range(0, 1), pick_addr(),
                  ($urandom_range(0, 9) < 6), pick_addr(),
                  wbe, wba,
                  ($urandom_range(0, 59) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size() == 0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
